// File: rtl/player_tx_arbiter.sv
// player_tx_arbiter: round-robin UART arbiter for two player status bytes, with periodic refresh.
// Define PLAYER_TX_HEADER_EN to prefix each data byte with a 0xA1/0xA2 player header byte.
module player_tx_arbiter #(
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        clean_rst,
    input  logic [7:0]  p1_data,
    input  logic [7:0]  p2_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    output logic        grant_id,
    output logic [15:0] frames_sent
);
    localparam int CW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES > 0 ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
`ifdef PLAYER_TX_HEADER_EN
        HDR_START,
        HDR_WAIT_BUSY,
        HDR_WAIT_DONE,
`endif
        DATA_START,
        DATA_WAIT_BUSY,
        DATA_WAIT_DONE
    } state_t;

`ifdef PLAYER_TX_HEADER_EN
    localparam state_t FIRST = HDR_START;
    logic [7:0] r_data;
    logic       w_hdr_done;
`else
    localparam state_t FIRST = DATA_START;
`endif

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_pend1, r_pend2;
    logic [7:0]    r_last1, r_last2, r_tx_byte;
    logic          r_grant;
    logic [15:0]   r_frames;
    logic          w_wrap, w_sel, w_grant, w_done;
    logic [7:0]    w_sel_data;

    assign w_wrap      = (REFRESH_CYCLES > 0) && (r_cnt == CNT_LAST);
    // both pending: favour whoever was not granted last (r_grant resets to P2 so P1 goes first)
    assign w_sel       = (r_pend1 && r_pend2) ? ~r_grant : r_pend2;
    assign w_sel_data  = w_sel ? p2_data : p1_data;
    assign tx_byte     = r_tx_byte;
    assign grant_id    = r_grant;
    assign frames_sent = r_frames;

    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        tx_start = 1'b0;
        w_grant  = 1'b0;
        w_done   = 1'b0;
`ifdef PLAYER_TX_HEADER_EN
        w_hdr_done = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_grant = (r_pend1 || r_pend2) && !tx_busy;
                w_next  = w_grant ? FIRST : IDLE;
            end
`ifdef PLAYER_TX_HEADER_EN
            HDR_START: begin
                tx_start = 1'b1;
                w_next   = HDR_WAIT_BUSY;
            end
            HDR_WAIT_BUSY: w_next = tx_busy ? HDR_WAIT_DONE : HDR_WAIT_BUSY;
            HDR_WAIT_DONE: begin
                w_hdr_done = !tx_busy;
                w_next     = tx_busy ? HDR_WAIT_DONE : DATA_START;
            end
`endif
            DATA_START: begin
                tx_start = 1'b1;
                w_next   = DATA_WAIT_BUSY;
            end
            DATA_WAIT_BUSY: w_next = tx_busy ? DATA_WAIT_DONE : DATA_WAIT_BUSY;
            DATA_WAIT_DONE: begin
                w_done = !tx_busy;
                w_next = tx_busy ? DATA_WAIT_DONE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clean_rst) begin
        if (clean_rst) begin
            r_cnt     <= '0;
            r_pend1   <= 1'b0;
            r_pend2   <= 1'b0;
            r_last1   <= 8'h00;
            r_last2   <= 8'h00;
            r_tx_byte <= 8'h00;
            r_grant   <= 1'b1;
            r_frames  <= 16'h0000;
`ifdef PLAYER_TX_HEADER_EN
            r_data    <= 8'h00;
`endif
        end else begin
            r_cnt   <= (w_wrap || REFRESH_CYCLES == 0) ? '0 : r_cnt + 1'b1;
            // a grant clears its own flag even on a refresh wrap
            r_pend1 <= (w_grant && !w_sel) ? 1'b0 : (r_pend1 || p1_data != r_last1 || w_wrap);
            r_pend2 <= (w_grant && w_sel) ? 1'b0 : (r_pend2 || p2_data != r_last2 || w_wrap);
            if (w_grant) begin
                r_grant <= w_sel;
                if (w_sel) r_last2 <= p2_data;
                else       r_last1 <= p1_data;
`ifdef PLAYER_TX_HEADER_EN
                r_data    <= w_sel_data;
                r_tx_byte <= w_sel ? 8'hA2 : 8'hA1;
`else
                r_tx_byte <= w_sel_data;
`endif
            end
`ifdef PLAYER_TX_HEADER_EN
            if (w_hdr_done) r_tx_byte <= r_data;
`endif
            if (w_done) r_frames <= r_frames + 16'd1;
        end
    end
endmodule

// File: tb/tb_player_tx_arbiter.sv
// tb_player_tx_arbiter: vector table, hand sequences and random episodes checked against a frame-level model.
module tb_player_tx_arbiter;
    typedef logic [8:0] ent_t;
    typedef struct {
        logic        rst;
        logic [7:0]  p1;
        logic [7:0]  p2;
        int          n;
        ent_t        e0;
        ent_t        e1;
        logic [15:0] f;
        logic        g;
    } vec_t;

`ifdef PLAYER_TX_HEADER_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    logic        clk = 1'b0, clean_rst = 1'b1;
    logic [7:0]  p1_data = 8'h00, p2_data = 8'h00, rp1 = 8'h00, rp2 = 8'h00;
    logic        tx_busy = 1'b0, busy2 = 1'b0;
    logic        tx_start, grant_id, start2, grant2;
    logic [7:0]  tx_byte, byte2;
    logic [15:0] frames_sent, frames2;
    int          errors = 0, checks = 0, busy_len1 = 0;
    ent_t        q1[$], q2[$], exp_q[$];
    logic [7:0]  m_last1 = 8'h00, m_last2 = 8'h00;
    logic        m_grant = 1'b1;
    logic [15:0] m_frames = 16'h0000;

    always #5 clk = ~clk;

    player_tx_arbiter dut (
        .clk(clk), .clean_rst(clean_rst), .p1_data(p1_data), .p2_data(p2_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
        .grant_id(grant_id), .frames_sent(frames_sent)
    );

    player_tx_arbiter #(.REFRESH_CYCLES(50)) dut2 (
        .clk(clk), .clean_rst(clean_rst), .p1_data(rp1), .p2_data(rp2),
        .tx_busy(busy2), .tx_start(start2), .tx_byte(byte2),
        .grant_id(grant2), .frames_sent(frames2)
    );

    initial forever begin
        @(negedge clk);
        if (tx_start) q1.push_back({grant_id, tx_byte});
        if (start2) q2.push_back({grant2, byte2});
    end

    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busy_len1 == 0 ? int'($urandom_range(12, 1)) : busy_len1) @(posedge clk);
            #1 tx_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (start2) begin
            @(posedge clk);
            #1 busy2 = 1'b1;
            repeat (6) @(posedge clk);
            #1 busy2 = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic add_frame(input logic g, input logic [7:0] b);
`ifdef PLAYER_TX_HEADER_EN
        exp_q.push_back({g, g ? 8'hA2 : 8'hA1});
`endif
        exp_q.push_back({g, b});
    endtask

    task automatic check_q(input string nm, input ent_t got[$]);
        chk($sformatf("%s pulses", nm), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s pulse%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        int n = 0;
        while (quiet < 10 && n < 3000) begin
            @(negedge clk);
            n++;
            quiet = (tx_busy || tx_start) ? 0 : quiet + 1;
        end
        if (quiet < 10) begin
            checks++;
            errors++;
            $display("FAIL quiet timeout");
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!tx_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_busy) begin
            checks++;
            errors++;
            $display("FAIL busy timeout");
        end
    endtask

    task automatic wait_pulses(input int k);
        int n = 0;
        while (q1.size() < k && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() < k) begin
            checks++;
            errors++;
            $display("FAIL pulse timeout: got %0d, want %0d", q1.size(), k);
        end
    endtask

    task automatic model_reset();
        m_last1 = 8'h00;
        m_last2 = 8'h00;
        m_grant = 1'b1;
        m_frames = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clean_rst = 1'b1;
        p1_data = 8'h00;
        p2_data = 8'h00;
        #1;
        chk("rst tx_start", tx_start, 0);
        chk("rst tx_byte", tx_byte, 0);
        chk("rst grant_id", grant_id, 1);
        chk("rst frames", frames_sent, 0);
        @(negedge clk);
        clean_rst = 1'b0;
        q1.delete();
        model_reset();
    endtask

    // frame-level model: changed players are sent once each, round-robin when both changed
    task automatic model_ep(input logic [7:0] a, input logic [7:0] b);
        logic d1, d2, first;
        d1 = a != m_last1;
        d2 = b != m_last2;
        if (d1 && d2) begin
            first = !m_grant;
            add_frame(first, first ? b : a);
            add_frame(!first, first ? a : b);
            m_grant = !first;
            m_frames += 16'd2;
        end else if (d1) begin
            add_frame(1'b0, a);
            m_grant = 1'b0;
            m_frames += 16'd1;
        end else if (d2) begin
            add_frame(1'b1, b);
            m_grant = 1'b1;
            m_frames += 16'd1;
        end
        m_last1 = a;
        m_last2 = b;
    endtask

    task automatic episode(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        p1_data = a;
        p2_data = b;
        wait_quiet();
    endtask

    initial begin
        vec_t tv[10];
        ent_t e;
        logic [7:0] a, b, v;
        tv[0] = '{1'b1, 8'h23, 8'h00, 1, 9'h023, 9'h000, 16'd1, 1'b0};
        tv[1] = '{1'b1, 8'h13, 8'h54, 2, 9'h013, 9'h154, 16'd2, 1'b1};
        tv[2] = '{1'b0, 8'h23, 8'h54, 1, 9'h023, 9'h000, 16'd3, 1'b0};
        tv[3] = '{1'b0, 8'h23, 8'h00, 1, 9'h100, 9'h000, 16'd4, 1'b1};
        tv[4] = '{1'b0, 8'h23, 8'h00, 0, 9'h000, 9'h000, 16'd4, 1'b1};
        tv[5] = '{1'b0, 8'h77, 8'h88, 2, 9'h077, 9'h188, 16'd6, 1'b1};
        tv[6] = '{1'b0, 8'h77, 8'h89, 1, 9'h189, 9'h000, 16'd7, 1'b1};
        tv[7] = '{1'b0, 8'h79, 8'h89, 1, 9'h079, 9'h000, 16'd8, 1'b0};
        tv[8] = '{1'b0, 8'h7A, 8'h8B, 2, 9'h18B, 9'h07A, 16'd10, 1'b0};
        tv[9] = '{1'b0, 8'h7A, 8'h45, 1, 9'h145, 9'h000, 16'd11, 1'b1};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (tv[i].rst) do_reset();
            episode(tv[i].p1, tv[i].p2);
            for (int k = 0; k < tv[i].n; k++) begin
                e = (k == 0) ? tv[i].e0 : tv[i].e1;
                add_frame(e[8], e[7:0]);
            end
            check_q($sformatf("vec%0d", i), q1);
            q1.delete();
            chk($sformatf("vec%0d frames", i), frames_sent, tv[i].f);
            chk($sformatf("vec%0d grant", i), grant_id, tv[i].g);
        end
        m_last1 = 8'h7A;
        m_last2 = 8'h45;
        m_grant = 1'b1;
        m_frames = 16'd11;
        // data changes while its frame is on the wire
        @(negedge clk);
        p1_data = 8'h30;
        wait_busy();
        p1_data = 8'h31;
        wait_quiet();
        add_frame(1'b0, 8'h30);
        add_frame(1'b0, 8'h31);
        check_q("midchange", q1);
        q1.delete();
        m_last1 = 8'h31;
        m_grant = 1'b0;
        m_frames += 16'd2;
        chk("midchange frames", frames_sent, m_frames);
        for (int i = 0; i < 25; i++) begin
            a = $urandom_range(1, 0) ? m_last1 : 8'($urandom);
            b = $urandom_range(1, 0) ? m_last2 : 8'($urandom);
            model_ep(a, b);
            episode(a, b);
            check_q($sformatf("rand%0d", i), q1);
            q1.delete();
            chk($sformatf("rand%0d frames", i), frames_sent, m_frames);
            chk($sformatf("rand%0d grant", i), grant_id, m_grant);
        end
        // reset while the data byte is still busy
        busy_len1 = 10;
        v = m_last1 ^ 8'h5A;
        @(negedge clk);
        p1_data = v;
        wait_pulses(NP);
        wait_busy();
        repeat (2) @(negedge clk);
        clean_rst = 1'b1;
        #1;
        chk("midrst tx_start", tx_start, 0);
        chk("midrst frames", frames_sent, 0);
        chk("midrst tx_byte", tx_byte, 0);
        chk("midrst grant", grant_id, 1);
        @(negedge clk);
        chk("midrst hold tx_start", tx_start, 0);
        chk("midrst hold frames", frames_sent, 0);
        clean_rst = 1'b0;
        q1.delete();
        model_reset();
        @(negedge clk);
        chk("postrst busy tx_start", tx_start, 0);
        model_ep(p1_data, p2_data);
        wait_quiet();
        check_q("postrst", q1);
        q1.delete();
        chk("postrst frames", frames_sent, m_frames);
        busy_len1 = 0;
        // static inputs on the 50-cycle refresh instance
        @(negedge clk);
        clean_rst = 1'b1;
        p1_data = 8'h00;
        p2_data = 8'h00;
        rp1 = 8'h11;
        rp2 = 8'h22;
        @(negedge clk);
        clean_rst = 1'b0;
        q2.delete();
        repeat (240) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            add_frame(1'b0, 8'h11);
            add_frame(1'b1, 8'h22);
        end
        check_q("refresh", q2);
        chk("refresh frames", frames2, 10);
        chk("refresh grant", grant2, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
